// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state type and default width for alu_seq.
package alu_seq_pkg;

    localparam int unsigned NBYTES_DEFAULT = 4;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_LSHIFT = 4'd2;
    localparam logic [3:0] OP_RSHIFT = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_CMP    = 4'd5;
    localparam logic [3:0] OP_AND    = 4'd6;
    localparam logic [3:0] OP_NAND   = 4'd7;
    localparam logic [3:0] OP_OR     = 4'd8;
    localparam logic [3:0] OP_NOR    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_e;

    function automatic logic msb_first(input logic [3:0] op);
        return (op == OP_RSHIFT) || (op == OP_CMP);
    endfunction

    function automatic logic is_known(input logic [3:0] op);
        return op <= OP_NOR;
    endfunction

    function automatic logic is_chained(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LSHIFT) || (op == OP_RSHIFT);
    endfunction

endpackage

// File: rtl/alu_seq_bytesel.sv
// Maps the issue counter to a byte index (LSB- or MSB-first by opcode)
// and extracts the matching operand bytes.
module alu_seq_bytesel
    import alu_seq_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEFAULT,
    parameter int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic [3:0]          i_op,
    input  logic [CW-1:0]       i_cnt,
    input  logic [8*NBYTES-1:0] i_a,
    input  logic [8*NBYTES-1:0] i_b,
    output logic [CW-1:0]       o_idx,
    output logic [7:0]          o_a_byte,
    output logic [7:0]          o_b_byte
);

    logic [CW-1:0] w_idx;

    always_comb begin
        w_idx    = msb_first(i_op) ? (CW'(NBYTES - 1) - i_cnt) : i_cnt;
        o_idx    = w_idx;
        o_a_byte = i_a[8*int'(w_idx) +: 8];
        o_b_byte = i_b[8*int'(w_idx) +: 8];
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-byte operation sequencer around an external 8-bit ALU.
// Optional feature: define ALU_SEQ_STATS_EN to enable the op_count counter.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [8*NBYTES-1:0] req_a,
    input  logic [8*NBYTES-1:0] req_b,
    input  logic                req_cin,
    output logic [7:0]          alu_opa,
    output logic [7:0]          alu_opb,
    output logic [3:0]          alu_opcode,
    output logic                alu_cin,
    input  logic [7:0]          alu_res,
    input  logic                alu_cout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [8*NBYTES-1:0] rsp_data,
    output logic                rsp_cout,
    output logic [15:0]         op_count
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_e        r_state;
    state_e        w_next;
    logic [3:0]    r_op;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic [W-1:0]  r_data;

    logic [CW-1:0] w_idx;
    logic [7:0]    w_abyte;
    logic [7:0]    w_bbyte;
    logic          w_last;

    alu_seq_bytesel #(.NBYTES(NBYTES), .CW(CW)) u_bytesel (
        .i_op     (r_op),
        .i_cnt    (r_cnt),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_idx    (w_idx),
        .o_a_byte (w_abyte),
        .o_b_byte (w_bbyte)
    );

    // CMP stops early on the first non-equal byte; unknown opcodes take one cycle.
    always_comb begin
        w_last = 1'b0;
        if (!is_known(r_op))
            w_last = 1'b1;
        else if ((r_op == OP_CMP) && (alu_res != 8'h01))
            w_last = 1'b1;
        else if (r_cnt == CW'(NBYTES - 1))
            w_last = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_next = ST_ISSUE;
            ST_ISSUE: if (w_last)    w_next = ST_DONE;
            ST_DONE:  if (rsp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_opa    = '0;
        alu_opb    = '0;
        alu_opcode = '0;
        alu_cin    = 1'b0;
        if (r_state == ST_ISSUE) begin
            alu_cin    = r_carry;
            alu_opcode = (r_op == OP_SUB) ? OP_ADD : r_op;
            case (r_op)
                OP_SUB: begin
                    alu_opa = w_abyte;
                    alu_opb = ~w_bbyte;
                end
                OP_LSHIFT: alu_opa = w_abyte;
                OP_RSHIFT: alu_opb = w_abyte;
                default: begin
                    alu_opa = w_abyte;
                    alu_opb = w_bbyte;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_cnt   <= '0;
                        r_data  <= '0;
                        r_carry <= (req_op == OP_SUB) ? 1'b1 :
                                   is_chained(req_op) ? req_cin : 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (is_chained(r_op))
                        r_carry <= alu_cout;
                    if (r_op == OP_CMP) begin
                        if (w_last)
                            r_data <= {{(W-8){1'b0}}, alu_res};
                    end else if (is_known(r_op)) begin
                        r_data[8*int'(w_idx) +: 8] <= alu_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_data  = r_data;
    assign rsp_cout  = r_carry;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_op_count <= '0;
        else if ((r_state == ST_DONE) && rsp_ready && (r_op_count != 16'hFFFF))
            r_op_count <= r_op_count + 16'd1;
    end

    assign op_count = r_op_count;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural 8-bit ALU attached.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned NB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [3:0]      req_op = '0;
    logic [8*NB-1:0] req_a = '0;
    logic [8*NB-1:0] req_b = '0;
    logic            req_cin = 1'b0;
    logic [7:0]      alu_opa, alu_opb, alu_res;
    logic [3:0]      alu_opcode;
    logic            alu_cin, alu_cout;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [8*NB-1:0] rsp_data;
    logic            rsp_cout;
    logic [15:0]     op_count;

    alu_seq #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .alu_opa    (alu_opa),
        .alu_opb    (alu_opb),
        .alu_opcode (alu_opcode),
        .alu_cin    (alu_cin),
        .alu_res    (alu_res),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // External 8-bit ALU.
    always_comb begin
        alu_res  = 8'h00;
        alu_cout = 1'b0;
        case (alu_opcode)
            OP_ADD:    {alu_cout, alu_res} = {1'b0, alu_opa} + {1'b0, alu_opb} + {8'h00, alu_cin};
            OP_LSHIFT: begin alu_res = {alu_opa[6:0], alu_cin}; alu_cout = alu_opa[7]; end
            OP_RSHIFT: begin alu_res = {alu_cin, alu_opb[7:1]}; alu_cout = alu_opb[0]; end
            OP_XOR:    alu_res = alu_opa ^ alu_opb;
            OP_AND:    alu_res = alu_opa & alu_opb;
            OP_NAND:   alu_res = ~(alu_opa & alu_opb);
            OP_OR:     alu_res = alu_opa | alu_opb;
            OP_NOR:    alu_res = ~(alu_opa | alu_opb);
            OP_CMP:    alu_res = (alu_opa == alu_opb) ? 8'h01 : (alu_opa > alu_opb) ? 8'h02 : 8'h03;
            default:   alu_res = 8'h00;
        endcase
    end

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        cout;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_acc = 0;
    int   n_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each new response, checks hold stability during stalls.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b1;
    logic [31:0] held_d;
    logic        held_c;
    exp_t        m_e;

    always @(negedge clk) begin
        if (rst_n && rsp_valid && !prev_v) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got data %0h with no pending request", rsp_data);
            end else begin
                m_e = sb.pop_front();
                chk({m_e.name, "_data"}, rsp_data, m_e.data);
                chk({m_e.name, "_cout"}, rsp_cout, m_e.cout);
                if (m_e.lat > 0)
                    chk({m_e.name, "_latency"}, cyc - t_acc, m_e.lat);
            end
            held_d = rsp_data;
            held_c = rsp_cout;
        end else if (rsp_valid && prev_v && !prev_r) begin
            chk("stall_data_stable", rsp_data, held_d);
            chk("stall_cout_stable", rsp_cout, held_c);
            chk("stall_req_ready", req_ready, 1'b0);
        end
        if (rst_n && rsp_valid && rsp_ready)
            n_hs++;
        prev_v = rsp_valid;
        prev_r = rsp_ready;
    end

    function automatic int exp_count();
`ifdef ALU_SEQ_STATS_EN
        return n_hs;
`else
        return 0;
`endif
    endfunction

    task automatic do_req(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin, input logic [31:0] ed,
                          input logic ec, input int el, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got req_ready 0 expected 1", nm);
        end
        chk({nm, "_idle_alu"}, {alu_opcode, alu_opa, alu_opb, alu_cin}, '0);
        e.name = nm;
        e.data = ed;
        e.cout = ec;
        e.lat  = el;
        sb.push_back(e);
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        @(posedge clk); #1;
        t_acc     = cyc;
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = ~b;
        req_cin   = ~cin;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_rsp_timeout: got rsp_valid 0 expected 1", nm);
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_cout", rsp_cout, 1'b0);
        chk("rst_op_count", op_count, '0);
        chk("rst_alu", {alu_opcode, alu_opa, alu_opb, alu_cin}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_req_ready", req_ready, 1'b1);

        do_req("add_ff_1",   OP_ADD,    32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 4, 0);
        do_req("add_wrap",   OP_ADD,    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 4, 0);
        do_req("sub_0_1",    OP_SUB,    32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 4, 0);
        do_req("sub_5_3",    OP_SUB,    32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b1, 4, 0);
        do_req("cmp_gt",     OP_CMP,    32'h1200_0000, 32'h1100_0000, 1'b0, 32'h0000_0002, 1'b0, 0, 0);
        do_req("cmp_lt_b2",  OP_CMP,    32'h1234_0000, 32'h1235_0000, 1'b0, 32'h0000_0003, 1'b0, 2, 0);
        do_req("cmp_eq",     OP_CMP,    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0001, 1'b0, 4, 0);
        do_req("rshift",     OP_RSHIFT, 32'h8000_0001, 32'h0000_0000, 1'b1, 32'hC000_0000, 1'b1, 4, 0);
        do_req("lshift",     OP_LSHIFT, 32'h8000_0001, 32'h0000_0000, 1'b0, 32'h0000_0002, 1'b1, 4, 0);
        do_req("xor",        OP_XOR,    32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'hFF00_EDCB, 1'b0, 4, 0);
        do_req("and",        OP_AND,    32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'h00F0_1234, 1'b0, 4, 0);
        do_req("nand",       OP_NAND,   32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'hFF0F_EDCB, 1'b0, 4, 0);
        do_req("or",         OP_OR,     32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'hFFF0_FFFF, 1'b0, 4, 0);
        do_req("nor",        OP_NOR,    32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'h000F_0000, 1'b0, 4, 0);
        do_req("op12",       4'd12,     32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h0000_0000, 1'b0, 1, 0);
        do_req("add_stall",  OP_ADD,    32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 4, 3);
        chk("op_count_pre_reset", op_count, exp_count());

        // Abort an ADD partway through ISSUE; no response may follow.
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_a     = 32'h1111_1111;
        req_b     = 32'h2222_2222;
        req_cin   = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("issue_alu_active", alu_opa, 8'h11);
        rst_n = 1'b0;
        n_hs  = 0;
        #2;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_rsp_data", rsp_data, '0);
        chk("midrst_alu", {alu_opcode, alu_opa, alu_opb, alu_cin}, '0);
        chk("midrst_op_count", op_count, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", rsp_valid, 1'b0);
        end

        do_req("add_after_rst", OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 4, 0);
        chk("op_count_final", op_count, exp_count());
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
